// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, operand classes
// and format-dependent constants.
package fpu_pkg;

  localparam int FLAG_INV = 3;
  localparam int FLAG_DZ  = 2;
  localparam int FLAG_OF  = 1;
  localparam int FLAG_UF  = 0;

  typedef enum logic [2:0] {
    NORM,
    ZERO,
    INF,
    QNAN,
    SNAN
  } fcls_e;

  function automatic logic [63:0] canon_nan(
    input int exp_w,
    input int man_w
  );
    logic [63:0] r;
    r = ((64'd1 << exp_w) - 64'd1) << man_w;
    r = r | (64'd1 << (man_w - 1));
    return r;
  endfunction

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fdiv_iter_stage.sv
// N restoring-division iterations, purely combinational.
// Quotient bits shift in at the LSB of q.
module fdiv_iter_stage #(
  parameter int N     = 4,
  parameter int WIDTH = 26
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] div_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] trial;

  always_comb begin
    rem   = rem_i;
    q     = q_i;
    trial = '0;
    for (int i = 0; i < N; i++) begin
      trial = rem - div_i;
      if (!trial[WIDTH-1]) begin
        q   = {q[WIDTH-2:0], 1'b1};
        rem = {trial[WIDTH-2:0], 1'b0};
      end else begin
        q   = {q[WIDTH-2:0], 1'b0};
        rem = {rem[WIDTH-2:0], 1'b0};
      end
    end
    rem_o = rem;
    q_o   = q;
  end

endmodule

// File: rtl/fdiv_pipe.sv
// Pipelined IEEE-754 divider: unpack, NSTG restoring divide
// stages, round/pack. Whole pipe stalls on output backpressure.
module fdiv_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W          = 8,
  parameter int MAN_W          = 23,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W          = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int Q_W  = MAN_W + 3;
  localparam int BPS  = BITS_PER_STAGE;
  localparam int NSTG = (Q_W + BPS - 1) / BPS;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = bias(EXP_W);

  localparam logic [W-1:0] CNAN =
    W'(canon_nan(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EMAX_S =
    EW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             sgn;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    fcls_e            ca;
    fcls_e            cb;
    logic [MAN_W:0]   mb;
    logic [Q_W-1:0]   rem;
    logic [Q_W-1:0]   q;
  } stg_t;

  function automatic fcls_e classify(
    input logic [EXP_W-1:0] ex,
    input logic [MAN_W-1:0] fr
  );
    if (ex == '0) return ZERO;
    if (&ex) begin
      if (fr == '0) return INF;
      return fr[MAN_W-1] ? QNAN : SNAN;
    end
    return NORM;
  endfunction

  logic            adv;
  logic [NSTG:0]   vld_q;
  stg_t            st_q [NSTG+1];
  stg_t            u_d;
  stg_t            rs;
  logic [Q_W-1:0]  rem_n [NSTG];
  logic [Q_W-1:0]  q_n [NSTG];

  logic            ov_q;
  logic [W-1:0]    res_q;
  logic [TAG_W-1:0] tag_q;
  logic [3:0]      flg_q;

  assign adv      = ~ov_q | out_ready;
  assign in_ready = adv;

  // Subnormals classify as ZERO, which flushes them.
  always_comb begin
    u_d     = '0;
    u_d.tag = in_tag;
    u_d.sgn = in_a[W-1] ^ in_b[W-1];
    u_d.ea  = in_a[W-2:MAN_W];
    u_d.eb  = in_b[W-2:MAN_W];
    u_d.ca  = classify(in_a[W-2:MAN_W], in_a[MAN_W-1:0]);
    u_d.cb  = classify(in_b[W-2:MAN_W], in_b[MAN_W-1:0]);
    u_d.mb  = {1'b1, in_b[MAN_W-1:0]};
    u_d.rem = {2'b00, 1'b1, in_a[MAN_W-1:0]};
    u_d.q   = '0;
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_div
    localparam int NI =
      (s == NSTG - 1) ? Q_W - BPS * (NSTG - 1) : BPS;
    fdiv_iter_stage #(
      .N     (NI),
      .WIDTH (Q_W)
    ) u_iter (
      .rem_i (st_q[s].rem),
      .div_i ({2'b00, st_q[s].mb}),
      .q_i   (st_q[s].q),
      .rem_o (rem_n[s]),
      .q_o   (q_n[s])
    );
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      st_q[0] <= u_d;
      for (int s = 0; s < NSTG; s++) begin
        st_q[s+1]     <= st_q[s];
        st_q[s+1].rem <= rem_n[s];
        st_q[s+1].q   <= q_n[s];
      end
    end
  end

  assign rs = st_q[NSTG];

  logic                   norm;
  logic                   grd;
  logic                   stk;
  logic                   inc;
  logic                   cy;
  logic [MAN_W-1:0]       fr;
  logic [MAN_W-1:0]       frac;
  logic signed [EW-1:0]   e;
  logic [W-1:0]           inf_v;
  logic [W-1:0]           zero_v;
  logic [W-1:0]           res_d;
  logic [3:0]             flg_d;

  always_comb begin
    norm = rs.q[Q_W-1];
    fr   = norm ? rs.q[Q_W-2:2] : rs.q[Q_W-3:1];
    grd  = norm ? rs.q[1] : rs.q[0];
    stk  = (|rs.rem) | (norm & rs.q[0]);
    inc  = grd & (stk | fr[0]);
    {cy, frac} = {1'b0, fr} + {{MAN_W{1'b0}}, inc};
    e = $signed({2'b00, rs.ea})
      - $signed({2'b00, rs.eb})
      + $signed(EW'(BIAS))
      + $signed({{(EW-1){1'b0}}, cy})
      - $signed({{(EW-1){1'b0}}, ~norm});
    inf_v  = {rs.sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    zero_v = {rs.sgn, {(W-1){1'b0}}};
    res_d  = {rs.sgn, e[EXP_W-1:0], frac};
    flg_d  = '0;
    if (rs.ca inside {QNAN, SNAN} ||
        rs.cb inside {QNAN, SNAN}) begin
      res_d = CNAN;
      flg_d[FLAG_INV] = (rs.ca == SNAN) | (rs.cb == SNAN);
    end else if ((rs.ca == ZERO && rs.cb == ZERO) ||
                 (rs.ca == INF && rs.cb == INF)) begin
      res_d = CNAN;
      flg_d[FLAG_INV] = 1'b1;
    end else if (rs.ca == INF) begin
      res_d = inf_v;
    end else if (rs.cb == INF) begin
      res_d = zero_v;
    end else if (rs.cb == ZERO) begin
      res_d = inf_v;
      flg_d[FLAG_DZ] = 1'b1;
    end else if (rs.ca == ZERO) begin
      res_d = zero_v;
    end else if (e >= EMAX_S) begin
      res_d = inf_v;
      flg_d[FLAG_OF] = 1'b1;
    end else if (e[EW-1] || e == '0) begin
      res_d = zero_v;
      flg_d[FLAG_UF] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      tag_q <= '0;
      flg_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[NSTG-1:0], in_valid};
      ov_q  <= vld_q[NSTG];
      res_q <= res_d;
      tag_q <= rs.tag;
      flg_q <= flg_d;
    end
  end

  assign out_valid  = ov_q;
  assign out_result = res_q;
  assign out_tag    = tag_q;
  assign out_flags  = flg_q;

endmodule
